// File: rtl/rc_pwm_dac.sv
`timescale 1ns/1ps
// Purpose: slew-limited PWM DAC; ramps duty toward a requested level, holds, then flags settled.
// Latency: one duty step per PWM period end; settled after ceil(|delta|/STEP)+SETTLE_PERIODS period ends (+<=1 clk).
// Backpressure: level_ready high only in IDLE; level_valid outside IDLE is dropped, never queued.
//
// Ports:
//   clki        sole clock
//   resetn      asynchronous active-low reset
//   level       requested duty (0 = always low), taken on level_valid & level_ready
//   level_valid request strobe, held by the requester until level_ready
//   level_ready high only while idle
//   out         push-pull drive to the RC network
//   busy        high whenever not idle
//   settled     last accepted level reached and held for SETTLE_PERIODS periods
//   disp        top four bits of the active duty, for LEDs
//
// Build option: define RC_PWM_DAC_SD_EN to replace the comparator PWM with a
// first-order sigma-delta modulator (same average, lower ripple).
module rc_pwm_dac #(
  parameter int WIDTH          = 8,
  parameter int STEP           = 16,
  parameter int SETTLE_PERIODS = 4
) (
  input  logic             clki,
  input  logic             resetn,
  input  logic [WIDTH-1:0] level,
  input  logic             level_valid,
  output logic             level_ready,
  output logic             out,
  output logic             busy,
  output logic             settled,
  output logic [3:0]       disp
);

  localparam int SW = (SETTLE_PERIODS < 1) ? 1 : $clog2(SETTLE_PERIODS + 1);
  localparam logic [WIDTH-1:0] STEP_N     = WIDTH'(STEP);
  localparam logic [SW-1:0]    SETTLE_MAX = SW'(SETTLE_PERIODS);

  typedef enum logic [1:0] {S_IDLE, S_RAMP, S_SETTLE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_cur;
  logic [WIDTH-1:0] r_target;
  logic [WIDTH-1:0] r_duty;
  logic [SW-1:0]    r_settle_cnt;
  logic             r_settled;

  logic             w_pe;
  logic             w_accept;
  logic             w_step_en;
  logic             w_settle_clr;
  logic             w_settle_inc;
  logic             w_set_settled;
  logic             w_up;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_cur_nxt;

  assign w_pe        = (r_cnt == '1);
  assign level_ready = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign settled     = r_settled;
  assign disp        = r_duty[WIDTH-1 -: 4];

  // Distance to target is taken one bit wider so the magnitude never wraps;
  // the step is the smaller of STEP and that distance, so cur lands exactly on target.
  assign w_up      = (r_target > r_cur);
  assign w_diff    = w_up ? ({1'b0, r_target} - {1'b0, r_cur})
                          : ({1'b0, r_cur} - {1'b0, r_target});
  assign w_step    = (w_diff > {1'b0, STEP_N}) ? STEP_N : w_diff[WIDTH-1:0];
  assign w_cur_nxt = w_up ? (r_cur + w_step) : (r_cur - w_step);

  always_ff @(posedge clki or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_step_en     = 1'b0;
    w_settle_clr  = 1'b0;
    w_settle_inc  = 1'b0;
    w_set_settled = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (level_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RAMP;
        end
      end
      S_RAMP: begin
        // Equality is tested before stepping, so a request equal to the
        // current duty goes straight to SETTLE without touching the duty.
        if (r_cur == r_target) begin
          w_settle_clr = 1'b1;
          w_state_nxt  = S_SETTLE;
        end else if (w_pe) begin
          w_step_en = 1'b1;
        end
      end
      S_SETTLE: begin
        if (r_settle_cnt == SETTLE_MAX) begin
          w_set_settled = 1'b1;
          w_state_nxt   = S_IDLE;
        end else if (w_pe) begin
          w_settle_inc = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clki or negedge resetn) begin
    if (!resetn) begin
      r_cnt        <= '0;
      r_cur        <= '0;
      r_target     <= '0;
      r_duty       <= '0;
      r_settle_cnt <= '0;
      r_settled    <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (w_accept) begin
        r_target  <= level;
        r_settled <= 1'b0;
      end else if (w_set_settled) begin
        r_settled <= 1'b1;
      end
      // Steps only happen on a period-end edge, so the new duty covers a
      // whole period starting at cnt == 0.
      if (w_step_en) begin
        r_cur  <= w_cur_nxt;
        r_duty <= w_cur_nxt;
      end
      if (w_settle_clr) begin
        r_settle_cnt <= '0;
      end else if (w_settle_inc) begin
        r_settle_cnt <= r_settle_cnt + 1'b1;
      end
    end
  end

`ifdef RC_PWM_DAC_SD_EN
  // Carry of the accumulator is the output bit; it is dropped before the
  // next add so the remainder alone carries forward.
  logic [WIDTH:0] r_acc;

  always_ff @(posedge clki or negedge resetn) begin
    if (!resetn) begin
      r_acc <= '0;
    end else begin
      r_acc <= {1'b0, r_acc[WIDTH-1:0]} + {1'b0, r_duty};
    end
  end

  assign out = r_acc[WIDTH];
`else
  logic r_out;

  always_ff @(posedge clki or negedge resetn) begin
    if (!resetn) begin
      r_out <= 1'b0;
    end else begin
      r_out <= (r_cnt < r_duty);
    end
  end

  assign out = r_out;
`endif

endmodule

// File: tb/tb_rc_pwm_dac.sv
`timescale 1ns/1ps
// Bench for rc_pwm_dac (WIDTH=8, STEP=16, SETTLE_PERIODS=4).
// Each accepted request is turned into a schedule (step edges, settle edge);
// outputs for any cycle are computed from that schedule with plain arithmetic.
module tb_rc_pwm_dac;

  localparam int W    = 8;
  localparam int STEP = 16;
  localparam int SP   = 4;
  localparam int PER  = 256;

  logic         clki        = 1'b0;
  logic         resetn      = 1'b1;
  logic [W-1:0] level       = '0;
  logic         level_valid = 1'b0;
  logic         level_ready;
  logic         out;
  logic         busy;
  logic         settled;
  logic [3:0]   disp;

  int n_cmp = 0;
  int n_err = 0;

  // n = number of clock edges since reset release, as seen in the current cycle.
  int n = -1;
  // Schedule of the most recently accepted request.
  bit t_vld    = 1'b0;
  int t_e      = 0;   // acceptance edge
  int t_base   = 0;   // duty before the request
  int t_tgt    = 0;
  int t_n      = 0;   // number of steps
  int t_m1     = 0;   // first step edge
  int t_settle = 0;   // edge at which settled rises
  int acc      = 0;

  always #5 clki = ~clki;

  rc_pwm_dac #(.WIDTH(W), .STEP(STEP), .SETTLE_PERIODS(SP)) dut (
    .clki        (clki),
    .resetn      (resetn),
    .level       (level),
    .level_valid (level_valid),
    .level_ready (level_ready),
    .out         (out),
    .busy        (busy),
    .settled     (settled),
    .disp        (disp)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, n);
    end
  endtask

  // Edge m is a period end when the counter read 2^W-1 before it, i.e. m % PER == 0.
  function automatic int duty_at(input int c);
    int k;
    int mag;
    int dlt;
    if (!t_vld || c < t_m1) return t_base;
    k = (c - t_m1) / PER + 1;
    if (k > t_n) k = t_n;
    mag = (t_tgt >= t_base) ? (t_tgt - t_base) : (t_base - t_tgt);
    dlt = (STEP * k < mag) ? STEP * k : mag;
    return (t_tgt >= t_base) ? (t_base + dlt) : (t_base - dlt);
  endfunction

  function automatic bit busy_at(input int c);
    return t_vld && c >= t_e && c < t_settle;
  endfunction

  function automatic bit settled_at(input int c);
    return t_vld && c >= t_settle;
  endfunction

  // Duty in the cycle the driver is in right now (driver acts just after a rising edge).
  function automatic int mdl_duty();
    return duty_at(n + 1);
  endfunction

  task automatic new_txn(input int e, input int lvl);
    int mag;
    int last;
    int p1;
    t_base = duty_at(e - 1);
    t_tgt  = lvl;
    mag    = (lvl >= t_base) ? (lvl - t_base) : (t_base - lvl);
    t_n    = (mag + STEP - 1) / STEP;
    t_m1   = ((e + PER) / PER) * PER;
    last   = (t_n == 0) ? e : t_m1 + PER * (t_n - 1);
    if (SP == 0) begin
      t_settle = last + 2;
    end else begin
      p1       = ((last + 2 + PER - 1) / PER) * PER;
      t_settle = p1 + PER * (SP - 1) + 1;
    end
    t_e   = e;
    t_vld = 1'b1;
  endtask

  // Per-cycle compare against the schedule.
  initial begin : cmp
    int exp_out;
    forever begin
      @(negedge clki);
      if (!resetn) begin
        n      = -1;
        t_vld  = 1'b0;
        t_base = 0;
        acc    = 0;
        check("rst_out", out, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", level_ready, 1);
        check("rst_settled", settled, 0);
        check("rst_disp", disp, 0);
      end else begin
        n++;
`ifdef RC_PWM_DAC_SD_EN
        if (n > 0) acc = (acc % PER) + duty_at(n - 1);
        exp_out = (acc >= PER) ? 1 : 0;
`else
        exp_out = (n > 0 && ((n - 1) % PER) < duty_at(n - 1)) ? 1 : 0;
`endif
        check("out", out, exp_out);
        check("busy", busy, busy_at(n));
        check("ready", level_ready, !busy_at(n));
        check("settled", settled, settled_at(n));
        check("disp", disp, duty_at(n) / 16);
        if (level_valid && !busy_at(n)) new_txn(n + 1, level);
      end
    end
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clki);
    #2;
  endtask

  task automatic wait_pe(input int k);
    int got = 0;
    int guard = 0;
    while (got < k && guard < PER * (k + 1)) begin
      @(posedge clki);
      guard++;
      if (((n + 1) % PER) == 0) got++;
    end
    #2;
    check("wait_pe_count", got, k);
  endtask

  task automatic req(input int lvl);
    int guard = 0;
    bit ok = 1'b0;
    @(posedge clki);
    #2;
    level       = W'(lvl);
    level_valid = 1'b1;
    while (!ok && guard < 10000) begin
      @(negedge clki);
      ok = level_ready;
      guard++;
      @(posedge clki);
      #2;
    end
    level_valid = 1'b0;
    check("req_accepted", ok, 1);
  endtask

  task automatic wait_settled(input int bound);
    int guard = 0;
    @(negedge clki);
    while (!settled && guard < bound) begin
      @(negedge clki);
      guard++;
    end
    check("settle_reached", settled, 1);
    @(posedge clki);
    #2;
  endtask

  task automatic high_count(output int hc);
    hc = 0;
    repeat (PER) begin
      @(negedge clki);
      if (out) hc++;
    end
    @(posedge clki);
    #2;
  endtask

  initial begin : drive
    int hc;
    #1 resetn = 1'b0;
    tick(3);
    resetn = 1'b1;
    check("init_ready", level_ready, 1);
    check("init_busy", busy, 0);

    // Ramp 0 -> 64 in four steps, then settle for four periods.
    req(64);
    check("s1_busy", busy, 1);
    check("s1_ready", level_ready, 0);
    for (int i = 1; i <= 4; i++) begin
      wait_pe(1);
      check("s1_disp", disp, i);
      check("s1_model_duty", mdl_duty(), 16 * i);
    end
    wait_pe(4);
    check("s1_settled_pre", settled, 0);
    tick(2);
    check("s1_settled", settled, 1);
    check("s1_ready_after", level_ready, 1);
    high_count(hc);
    check("s1_high", hc, 64);

    // 64 -> 60: single clamped step, then same level again.
    req(60);
    wait_pe(1);
    check("s2_disp", disp, 3);
    check("s2_model_duty", mdl_duty(), 60);
    wait_settled(6 * PER);
    req(60);
    check("s2_busy_again", busy, 1);
    check("s2_settled_clr", settled, 0);
    wait_settled(6 * PER);
    check("s2_disp_again", disp, 3);
    high_count(hc);
    check("s2_high", hc, 60);

    // 60 -> 0, then full-scale up and back down.
    req(0);
    wait_settled(10 * PER);
    check("s3_zero_model", mdl_duty(), 0);
    req(255);
    wait_pe(8);
    check("s3_mid_disp", disp, 8);
    wait_pe(7);
    check("s3_pe15_model", mdl_duty(), 240);
    check("s3_pe15_disp", disp, 15);
    wait_pe(1);
    check("s3_pe16_model", mdl_duty(), 255);
    wait_settled(6 * PER);
    high_count(hc);
    check("s3_high_255", hc, 255);
    req(0);
    wait_pe(16);
    check("s3_down_model", mdl_duty(), 0);
    check("s3_down_disp", disp, 0);
    wait_settled(6 * PER);
    high_count(hc);
    check("s3_high_0", hc, 0);

    // Request during ramp is ignored.
    req(128);
    wait_pe(2);
    level       = 8'd200;
    level_valid = 1'b1;
    @(negedge clki);
    check("s4_ready_low", level_ready, 0);
    @(posedge clki);
    #2;
    level_valid = 1'b0;
    wait_settled(16 * PER);
    check("s4_model_duty", mdl_duty(), 128);
    check("s4_disp", disp, 8);
    high_count(hc);
    check("s4_high", hc, 128);

    // Async reset mid-ramp at duty 32.
    resetn = 1'b0;
    tick(2);
    resetn = 1'b1;
    req(64);
    wait_pe(2);
    check("s5_disp", disp, 2);
    tick(5);
    check("s5_out_high", out, 1);
    resetn = 1'b0;
    #1;
    check("s5_rst_out", out, 0);
    check("s5_rst_busy", busy, 0);
    check("s5_rst_disp", disp, 0);
    check("s5_rst_settled", settled, 0);
    check("s5_rst_ready", level_ready, 1);
    tick(2);
    resetn = 1'b1;
    req(16);
    wait_settled(8 * PER);
    check("s5_after_disp", disp, 1);
    high_count(hc);
    check("s5_after_high", hc, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
